ex_mem_forward: RTL and testbench

EX_MEM_FORWARD -- requirements
Module: ex_mem_forward

---
 rtl/ex_mem_forward_pkg.sv | 46 ++++
 rtl/ex_mem_forward_if.sv | 55 +++++
 rtl/ex_mem_forward_forwarding_unit.sv | 43 ++++
 rtl/ex_mem_forward.sv | 73 +++++++
 tb/tb_ex_mem_forward.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_forward_pkg.sv
// ============================================================================
// Module  : ex_mem_forward_pkg
// Purpose : Shared pipeline definitions for the EX/MEM register and the
//           operand forwarding comparator: forward-select encodings, control
//           bit positions and the forwarding priority function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mem_forward_pkg;

    // ALU operand-select codes; 2'b11 is never produced.
    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Control field widths and bit positions.
    localparam int WB_W            = 2;
    localparam int MEM_W           = 2;
    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;
    localparam int MEM_READ_BIT    = 0;
    localparam int MEM_WRITE_BIT   = 1;

    // Priority select for one operand: the younger EX/MEM result wins over
    // MEM/WB, and register 0 is hard-wired so it is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic       exmem_regwrite,
        input logic [7:0] exmem_rd,
        input logic       memwb_regwrite,
        input logic [7:0] memwb_rd,
        input logic [7:0] operand
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (exmem_regwrite && (exmem_rd != 8'd0) && (exmem_rd == operand)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd != 8'd0) && (memwb_rd == operand)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_forward_if.sv
// ============================================================================
// Module  : ex_mem_forward_if
// Purpose : Bundles the EX-stage inputs, hazard-detection inputs and the
//           EX/MEM register / forwarding outputs of ex_mem_forward.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_mem_forward_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    // EX-stage values captured into the EX/MEM register
    logic [1:0]        WB_i;
    logic [1:0]        MEM_i;
    logic [DATA_W-1:0] ALUOut_i;
    logic [DATA_W-1:0] mux7_i;
    logic [REG_W-1:0]  mux8_i;

    // Operands of the instruction in EX and the MEM/WB writer
    logic [REG_W-1:0]  ID_EX_RegRs_i;
    logic [REG_W-1:0]  ID_EX_RegRt_i;
    logic              MEM_WB_RegWrite_i;
    logic [REG_W-1:0]  MEM_WB_RegRd_i;

    // EX/MEM register contents
    logic [1:0]        WB_o;
    logic [DATA_W-1:0] ALUOut_o;
    logic [DATA_W-1:0] mux7_o;
    logic [REG_W-1:0]  mux8_o;
    logic              memRead_o;
    logic              memWrite_o;

    // Operand select codes
    logic [1:0]        ForwardA_o;
    logic [1:0]        ForwardB_o;

    // Pipeline-register side
    modport slave (
        input  WB_i, MEM_i, ALUOut_i, mux7_i, mux8_i,
        input  ID_EX_RegRs_i, ID_EX_RegRt_i, MEM_WB_RegWrite_i, MEM_WB_RegRd_i,
        output WB_o, ALUOut_o, mux7_o, mux8_o, memRead_o, memWrite_o,
        output ForwardA_o, ForwardB_o
    );

    // Surrounding pipeline side
    modport master (
        output WB_i, MEM_i, ALUOut_i, mux7_i, mux8_i,
        output ID_EX_RegRs_i, ID_EX_RegRt_i, MEM_WB_RegWrite_i, MEM_WB_RegRd_i,
        input  WB_o, ALUOut_o, mux7_o, mux8_o, memRead_o, memWrite_o,
        input  ForwardA_o, ForwardB_o
    );
endinterface

`default_nettype wire

// File: rtl/ex_mem_forward_forwarding_unit.sv
// ============================================================================
// Module  : forwarding_unit
// Purpose : Combinational comparator choosing the ALU operand source for Rs
//           and Rt from the EX/MEM and MEM/WB destination registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module forwarding_unit
    import ex_mem_forward_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  wire logic             exmem_regwrite,
    input  wire logic [REG_W-1:0] exmem_rd,
    input  wire logic             memwb_regwrite,
    input  wire logic [REG_W-1:0] memwb_rd,
    input  wire logic [REG_W-1:0] rs,
    input  wire logic [REG_W-1:0] rt,
    output logic      [1:0]       forward_a,
    output logic      [1:0]       forward_b
);

    // Register numbers widened to the comparator width used by fwd_select.
    logic [7:0] exmem_rd_w;
    logic [7:0] memwb_rd_w;
    logic [7:0] rs_w;
    logic [7:0] rt_w;

    assign exmem_rd_w = 8'(exmem_rd);
    assign memwb_rd_w = 8'(memwb_rd);
    assign rs_w       = 8'(rs);
    assign rt_w       = 8'(rt);

    // Rs and Rt are judged independently with the same priority rule.
    always_comb begin
        forward_a = fwd_select(exmem_regwrite, exmem_rd_w, memwb_regwrite, memwb_rd_w, rs_w);
        forward_b = fwd_select(exmem_regwrite, exmem_rd_w, memwb_regwrite, memwb_rd_w, rt_w);
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_forward.sv
// ============================================================================
// Module  : ex_mem_forward
// Purpose : EX/MEM pipeline register with operand forwarding selection.
//           Captures the EX-stage results every cycle and derives ForwardA/B
//           from the registered destination plus the MEM/WB writer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_forward
    import ex_mem_forward_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  wire logic         clk_i,
    input  wire logic         rst_n,
    ex_mem_forward_if.slave   bus
);

    logic [WB_W-1:0]   wb_reg;
    logic [MEM_W-1:0]  mem_reg;
    logic [DATA_W-1:0] alu_reg;
    logic [DATA_W-1:0] store_reg;
    logic [REG_W-1:0]  rd_reg;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;

    // EX/MEM register: unconditional capture every cycle, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg    <= '0;
            mem_reg   <= '0;
            alu_reg   <= '0;
            store_reg <= '0;
            rd_reg    <= '0;
        end else begin
            wb_reg    <= bus.WB_i;
            mem_reg   <= bus.MEM_i;
            alu_reg   <= bus.ALUOut_i;
            store_reg <= bus.mux7_i;
            rd_reg    <= bus.mux8_i;
        end
    end

    assign bus.WB_o       = wb_reg;
    assign bus.ALUOut_o   = alu_reg;
    assign bus.mux7_o     = store_reg;
    assign bus.mux8_o     = rd_reg;
    assign bus.memRead_o  = mem_reg[MEM_READ_BIT];
    assign bus.memWrite_o = mem_reg[MEM_WRITE_BIT];

    // The EX/MEM side of the comparator sees only registered values, so a
    // cleared register can never request EX/MEM forwarding.
    forwarding_unit #(
        .REG_W (REG_W)
    ) u_forwarding_unit (
        .exmem_regwrite (wb_reg[WB_REGWRITE_BIT]),
        .exmem_rd       (rd_reg),
        .memwb_regwrite (bus.MEM_WB_RegWrite_i),
        .memwb_rd       (bus.MEM_WB_RegRd_i),
        .rs             (bus.ID_EX_RegRs_i),
        .rt             (bus.ID_EX_RegRt_i),
        .forward_a      (forward_a),
        .forward_b      (forward_b)
    );

    assign bus.ForwardA_o = forward_a;
    assign bus.ForwardB_o = forward_b;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_forward.sv
// ============================================================================
// Module  : tb_ex_mem_forward
// Purpose : Self-checking bench for ex_mem_forward: vector table with a
//           scoreboard queue, plus reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_forward;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ex_mem_forward_if #(.DATA_W(32), .REG_W(5)) bus ();

    ex_mem_forward #(
        .DATA_W (32),
        .REG_W  (5)
    ) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic [31:0] alu;
        logic [31:0] mux7;
        logic [4:0]  mux8;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        mwe;
        logic [4:0]  mrd;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } vec_t;

    typedef struct packed {
        logic [1:0]  wb;
        logic        rd;
        logic        wr;
        logic [31:0] alu;
        logic [31:0] mux7;
        logic [4:0]  mux8;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.WB_i              = v.wb;
        bus.MEM_i             = v.mem;
        bus.ALUOut_i          = v.alu;
        bus.mux7_i            = v.mux7;
        bus.mux8_i            = v.mux8;
        bus.ID_EX_RegRs_i     = v.rs;
        bus.ID_EX_RegRt_i     = v.rt;
        bus.MEM_WB_RegWrite_i = v.mwe;
        bus.MEM_WB_RegRd_i    = v.mrd;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.wb   = v.wb;
        e.rd   = v.mem[0];
        e.wr   = v.mem[1];
        e.alu  = v.alu;
        e.mux7 = v.mux7;
        e.mux8 = v.mux8;
        e.fa   = v.fa;
        e.fb   = v.fb;
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_WB_o"},       64'(bus.WB_o),       64'(e.wb));
            check({tag, "_memRead_o"},  64'(bus.memRead_o),  64'(e.rd));
            check({tag, "_memWrite_o"}, 64'(bus.memWrite_o), 64'(e.wr));
            check({tag, "_ALUOut_o"},   64'(bus.ALUOut_o),   64'(e.alu));
            check({tag, "_mux7_o"},     64'(bus.mux7_o),     64'(e.mux7));
            check({tag, "_mux8_o"},     64'(bus.mux8_o),     64'(e.mux8));
            check({tag, "_ForwardA_o"}, 64'(bus.ForwardA_o), 64'(e.fa));
            check({tag, "_ForwardB_o"}, 64'(bus.ForwardB_o), 64'(e.fb));
        end
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_WB_o"},       64'(bus.WB_o),       64'd0);
        check({tag, "_memRead_o"},  64'(bus.memRead_o),  64'd0);
        check({tag, "_memWrite_o"}, 64'(bus.memWrite_o), 64'd0);
        check({tag, "_ALUOut_o"},   64'(bus.ALUOut_o),   64'd0);
        check({tag, "_mux7_o"},     64'(bus.mux7_o),     64'd0);
        check({tag, "_mux8_o"},     64'(bus.mux8_o),     64'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;

        //            wb     mem    alu           mux7          mux8      rs        rt        mwe   mrd       fa     fb
        vecs[0] = '{2'b11, 2'b01, 32'd0,        32'd155,      5'b10110, 5'b10101, 5'b10110, 1'b1, 5'b11111, 2'b00, 2'b10};
        vecs[1] = '{2'b10, 2'b10, 32'hDEADBEEF, 32'h00001234, 5'b00101, 5'b00101, 5'b00101, 1'b1, 5'b00101, 2'b10, 2'b10};
        vecs[2] = '{2'b11, 2'b00, 32'h0000FFFF, 32'h00000001, 5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 2'b00, 2'b00};
        vecs[3] = '{2'b01, 2'b11, 32'h12345678, 32'h87654321, 5'b00111, 5'b00011, 5'b00111, 1'b1, 5'b00111, 2'b00, 2'b01};
        vecs[4] = '{2'b10, 2'b01, 32'hFFFFFFFF, 32'hA5A5A5A5, 5'b01000, 5'b01000, 5'b01001, 1'b1, 5'b01001, 2'b10, 2'b01};
        vecs[5] = '{2'b10, 2'b10, 32'h00000042, 32'h5A5A5A5A, 5'b01010, 5'b00001, 5'b00010, 1'b0, 5'b00001, 2'b00, 2'b00};
        vecs[6] = '{2'b00, 2'b00, 32'h80000000, 32'h7FFFFFFF, 5'b11111, 5'b11111, 5'b11111, 1'b1, 5'b11111, 2'b01, 2'b01};
        vecs[7] = '{2'b10, 2'b11, 32'hCAFEF00D, 32'h0BADF00D, 5'b00011, 5'b11100, 5'b00011, 1'b1, 5'b11100, 2'b01, 2'b10};

        // Reset asserted before any clock edge: registers clear at once.
        rst_n = 1'b0;
        bus.WB_i = 2'b11; bus.MEM_i = 2'b11;
        bus.ALUOut_i = 32'h1111_1111; bus.mux7_i = 32'h2222_2222; bus.mux8_i = 5'b10101;
        bus.ID_EX_RegRs_i = 5'b10101; bus.ID_EX_RegRt_i = 5'b10110;
        bus.MEM_WB_RegWrite_i = 1'b1; bus.MEM_WB_RegRd_i = 5'b11111;
        #2;
        check_regs_zero("reset_noclk");
        check("reset_noclk_ForwardA_o", 64'(bus.ForwardA_o), 64'd0);
        check("reset_noclk_ForwardB_o", 64'(bus.ForwardB_o), 64'd0);

        // MEM/WB path stays live in reset; EX/MEM path is held off even
        // across a clock edge with a matching input destination.
        bus.MEM_WB_RegRd_i = 5'b10101;
        @(posedge clk);
        #1;
        check_regs_zero("reset_clk");
        check("reset_clk_ForwardA_o", 64'(bus.ForwardA_o), 64'b01);
        check("reset_clk_ForwardB_o", 64'(bus.ForwardB_o), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            push_exp(vecs[i]);
            @(posedge clk);
            #1;
            compare_out($sformatf("vec%0d", i));
        end

        // Mid-cycle reset after loading vec7: outputs clear before next edge.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_regs_zero("midrst");
        // rs no longer matches the MEM/WB writer, rt matched only the
        // cleared EX/MEM entry, so both fall back to 00.
        bus.ID_EX_RegRs_i = 5'b00011;
        #1;
        check("midrst_ForwardA_o", 64'(bus.ForwardA_o), 64'd0);
        check("midrst_ForwardB_o", 64'(bus.ForwardB_o), 64'd0);

        // Release and confirm the register resumes capturing.
        @(negedge clk);
        rst_n = 1'b1;
        v = '{2'b10, 2'b01, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'b01100, 5'b01100, 5'b00000, 1'b1, 5'b00000, 2'b10, 2'b00};
        drive(v);
        push_exp(v);
        @(posedge clk);
        #1;
        compare_out("recover");

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
